// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg
//   Shared types and constants for the CPU-to-Avalon bus master.
//   - bus_state_t : sequencer states (IDLE, REQ, RESP, DONE)
//   - bus_port_t  : which CPU port owns the current transaction
//   - BE_WORD     : full-word byte enable used for instruction fetches
//   - ERR_WORD    : read data returned to the CPU on a timeout abort
//   With MIPS_BUS_MISALIGN_CHECK_EN defined, also provides is_misaligned().
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } bus_state_t;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } bus_port_t;

  localparam logic [3:0]  BE_WORD  = 4'b1111;
  localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

`ifdef MIPS_BUS_MISALIGN_CHECK_EN
  // A word access must be word aligned; a halfword access must be halfword aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [3:0] be);
    logic two_lane;
    case (be)
      4'b0011, 4'b0101, 4'b0110,
      4'b1001, 4'b1010, 4'b1100: two_lane = 1'b1;
      default:                   two_lane = 1'b0;
    endcase
    is_misaligned = ((be == BE_WORD) && (addr_lo != 2'b00)) ||
                    (two_lane && addr_lo[0]);
  endfunction
`endif

endpackage

// File: rtl/mips_bus_wait_counter.sv
// mips_bus_wait_counter
//   Saturating up-counter of enabled cycles with a "limit reached this cycle" flag.
//   limit_hit is high in the cycle whose enabled edge brings the count to limit,
//   so the owner can act on the same edge. A limit of zero never hits.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   clear       : synchronous clear (owner leaves the counted state)
//   enable      : count this cycle
//   limit       : terminal count
//   limit_hit   : enable && (count + 1 == limit)
module mips_bus_wait_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         limit_hit
);

  logic [W-1:0] count_r;
  logic [W:0]   count_inc_s;

  // Widened increment so a zero limit cannot match after a wrap
  always_comb begin
    count_inc_s = {1'b0, count_r} + {{W{1'b0}}, 1'b1};
    limit_hit   = enable && (count_inc_s == {1'b0, limit});
  end

  // Enabled-cycle counter, held at all-ones once saturated
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_r <= {W{1'b0}};
    end else if (enable && !(&count_r)) begin
      count_r <= count_inc_s[W-1:0];
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/mips_cpu_bus_master.sv
// mips_cpu_bus_master
//   Avalon-MM master that serialises the CPU fetch port and data port onto one
//   32-bit bus. Data requests win over fetches. Every transaction runs
//   IDLE -> REQ -> (RESP x READ_LATENCY for reads) -> DONE, and DONE carries a
//   one-cycle *_valid pulse to the owning port.
// Parameters:
//   READ_LATENCY : cycles from the accepting edge to valid readdata (1..4)
//   WAIT_TIMEOUT : consecutive waitrequest cycles before abort (0 = never)
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   instr_req/instr_addr             : fetch request (held until instr_valid)
//   instr_valid/instr_rdata          : fetch completion pulse and word
//   data_req/we/addr/wdata/byteenable: load/store request (held until data_valid)
//   data_valid/data_rdata            : load/store completion pulse and load word
//   bus_error                        : pulses with *_valid on a timeout abort
//   address/read/write/writedata/byteenable/waitrequest/readdata : Avalon-MM
// Build option:
//   MIPS_BUS_MISALIGN_CHECK_EN adds output 'misaligned'; misaligned requests are
//   completed locally with rdata=0 instead of being issued. Without it the low
//   address bits are simply masked.
module mips_cpu_bus_master
  import mips_bus_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_valid,
  output logic [31:0] instr_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteenable,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        bus_error,
`ifdef MIPS_BUS_MISALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  bus_state_t  state_r;
  bus_port_t   port_r;
  logic        we_r;

  logic        sel_valid_s;
  bus_port_t   sel_port_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [3:0]  sel_be_s;
  logic        misalign_s;

  logic        wait_hit_s;
  logic        lat_hit_s;
  logic        timeout_s;

  // Fixed-priority port selection; the word address drops the byte offset
  always_comb begin
    sel_valid_s = data_req || instr_req;
    if (data_req) begin
      sel_port_s  = PORT_DATA;
      sel_we_s    = data_we;
      sel_addr_s  = {data_addr[31:2], 2'b00};
      sel_wdata_s = data_wdata;
      sel_be_s    = data_byteenable;
    end else begin
      sel_port_s  = PORT_INSTR;
      sel_we_s    = 1'b0;
      sel_addr_s  = {instr_addr[31:2], 2'b00};
      sel_wdata_s = 32'h0000_0000;
      sel_be_s    = BE_WORD;
    end
  end

`ifdef MIPS_BUS_MISALIGN_CHECK_EN
  // Alignment check on the selected request
  always_comb begin
    if (data_req) begin
      misalign_s = is_misaligned(data_addr[1:0], data_byteenable);
    end else begin
      misalign_s = is_misaligned(instr_addr[1:0], BE_WORD);
    end
  end
`else
  logic unused_addr_lo_s;
  assign unused_addr_lo_s = ^{data_addr[1:0], instr_addr[1:0]};
  assign misalign_s       = 1'b0;
`endif

  // Timeout only applies when enabled
  always_comb begin
    if (WAIT_TIMEOUT != 0) begin
      timeout_s = wait_hit_s;
    end else begin
      timeout_s = 1'b0;
    end
  end

  mips_bus_wait_counter #(.W(16)) u_wait_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_r != REQ),
    .enable    ((state_r == REQ) && waitrequest),
    .limit     (16'(WAIT_TIMEOUT)),
    .limit_hit (wait_hit_s)
  );

  mips_bus_wait_counter #(.W(3)) u_lat_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_r != RESP),
    .enable    (state_r == RESP),
    .limit     (3'(READ_LATENCY)),
    .limit_hit (lat_hit_s)
  );

  // Bus sequencer: request capture, strobes, response capture, completion pulses.
  // Completion pulses are set on the edge entering DONE so they are high in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      port_r      <= PORT_INSTR;
      we_r        <= 1'b0;
      address     <= 32'h0000_0000;
      read        <= 1'b0;
      write       <= 1'b0;
      writedata   <= 32'h0000_0000;
      byteenable  <= 4'b0000;
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;
      bus_error   <= 1'b0;
      instr_rdata <= 32'h0000_0000;
      data_rdata  <= 32'h0000_0000;
`ifdef MIPS_BUS_MISALIGN_CHECK_EN
      misaligned  <= 1'b0;
`endif
    end else begin
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;
      bus_error   <= 1'b0;
`ifdef MIPS_BUS_MISALIGN_CHECK_EN
      misaligned  <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (sel_valid_s && misalign_s) begin
            // Completed locally, never reaches the bus
            port_r      <= sel_port_s;
            we_r        <= sel_we_s;
            instr_valid <= (sel_port_s == PORT_INSTR);
            data_valid  <= (sel_port_s == PORT_DATA);
            if (sel_port_s == PORT_DATA) begin
              data_rdata <= 32'h0000_0000;
            end else begin
              instr_rdata <= 32'h0000_0000;
            end
`ifdef MIPS_BUS_MISALIGN_CHECK_EN
            misaligned  <= 1'b1;
`endif
            state_r     <= DONE;
          end else if (sel_valid_s) begin
            port_r     <= sel_port_s;
            we_r       <= sel_we_s;
            address    <= sel_addr_s;
            writedata  <= sel_wdata_s;
            byteenable <= sel_be_s;
            read       <= !sel_we_s;
            write      <= sel_we_s;
            state_r    <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (we_r) begin
              data_valid <= 1'b1;
              state_r    <= DONE;
            end else begin
              state_r <= RESP;
            end
          end else if (timeout_s) begin
            read        <= 1'b0;
            write       <= 1'b0;
            bus_error   <= 1'b1;
            instr_valid <= (port_r == PORT_INSTR);
            data_valid  <= (port_r == PORT_DATA);
            if (port_r == PORT_DATA) begin
              data_rdata <= ERR_WORD;
            end else begin
              instr_rdata <= ERR_WORD;
            end
            state_r     <= DONE;
          end else begin
            // Stalled: every bus output keeps its value
            state_r <= REQ;
          end
        end
        RESP: begin
          if (lat_hit_s) begin
            if (port_r == PORT_DATA) begin
              data_rdata <= readdata;
            end else begin
              instr_rdata <= readdata;
            end
            instr_valid <= (port_r == PORT_INSTR);
            data_valid  <= (port_r == PORT_DATA);
            state_r     <= DONE;
          end else begin
            state_r <= RESP;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          read    <= 1'b0;
          write   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// tb_mips_cpu_bus_master
//   Directed bench for mips_cpu_bus_master with a small wait-state RAM model
//   (read latency 1). waitrequest modes: 0 = never stall, 1 = stall the first
//   cycle of each strobe, 2 = always stall. WAIT_TIMEOUT is set to 8.
module tb_mips_cpu_bus_master;
  import mips_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_byteenable;
  logic        data_valid;
  logic [31:0] data_rdata;
  logic        bus_error;
`ifdef MIPS_BUS_MISALIGN_CHECK_EN
  logic        misaligned;
`endif
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  int checks   = 0;
  int failures = 0;

  // RAM model state
  logic [31:0] mem [0:63];
  logic [1:0]  wr_mode = 2'd0;
  logic        stalled_r = 1'b0;

  // Bus monitor counters
  int   instr_pulses  = 0;
  int   data_pulses   = 0;
  int   stall_cnt     = 0;
  int   strobe_cycles = 0;
  int   rw_both_cnt   = 0;
  int   hold_viol_cnt = 0;
  logic prev_stall_r  = 1'b0;
  logic [69:0] prev_bus_r = 70'h0;

  mips_cpu_bus_master #(.READ_LATENCY(1), .WAIT_TIMEOUT(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_req       (instr_req),
    .instr_addr      (instr_addr),
    .instr_valid     (instr_valid),
    .instr_rdata     (instr_rdata),
    .data_req        (data_req),
    .data_we         (data_we),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_byteenable (data_byteenable),
    .data_valid      (data_valid),
    .data_rdata      (data_rdata),
    .bus_error       (bus_error),
`ifdef MIPS_BUS_MISALIGN_CHECK_EN
    .misaligned      (misaligned),
`endif
    .address         (address),
    .read            (read),
    .write           (write),
    .waitrequest     (waitrequest),
    .writedata       (writedata),
    .byteenable      (byteenable),
    .readdata        (readdata)
  );

  always #5 clk = ~clk;

  // Slave stall pattern
  always_comb begin
    case (wr_mode)
      2'd1:    waitrequest = (read || write) && !stalled_r;
      2'd2:    waitrequest = 1'b1;
      default: waitrequest = 1'b0;
    endcase
  end

  // RAM model: registered readdata one cycle after acceptance, lane writes
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0000_0000;
      mem[0]    <= 32'h2402_0005;
      stalled_r <= 1'b0;
    end else begin
      if (read && !waitrequest) readdata <= mem[address[7:2]];
      if (write && !waitrequest) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) mem[address[7:2]][8*b +: 8] <= writedata[8*b +: 8];
      end
      if ((read || write) && waitrequest) stalled_r <= 1'b1;
      else if (read || write) stalled_r <= 1'b0;
    end
  end

  // Bus monitor: pulse/stall counts, read&write overlap, hold during stalls
  always @(posedge clk) begin
    instr_pulses  <= instr_pulses + (instr_valid ? 1 : 0);
    data_pulses   <= data_pulses + (data_valid ? 1 : 0);
    stall_cnt     <= stall_cnt + (((read || write) && waitrequest) ? 1 : 0);
    strobe_cycles <= strobe_cycles + ((read || write) ? 1 : 0);
    if (read && write) rw_both_cnt <= rw_both_cnt + 1;
    if (reset) begin
      prev_stall_r <= 1'b0;
    end else begin
      if (prev_stall_r && !bus_error &&
          ({address, writedata, byteenable, read, write} != prev_bus_r))
        hold_viol_cnt <= hold_viol_cnt + 1;
      prev_stall_r <= (read || write) && waitrequest;
    end
    prev_bus_r <= {address, writedata, byteenable, read, write};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // which: 0 = instr_valid, 1 = data_valid, 2 = read or write strobe
  task automatic wait_sig(input string tag, input int which, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = instr_valid;
        1:       hit = data_valid;
        2:       hit = read || write;
        default: hit = 1'b0;
      endcase
    end
    checks++;
    assert (hit === 1'b1) else begin
      failures++;
      $display("FAIL %s: observed=timeout expected=event within %0d cycles", tag, budget);
      $error("wait %s", tag);
    end
  endtask

  int snap_a;
  int snap_b;

  initial begin
    reset = 1'b1; instr_req = 1'b0; instr_addr = 32'h0; data_req = 1'b0; data_we = 1'b0;
    data_addr = 32'h0; data_wdata = 32'h0; data_byteenable = 4'b0000;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_address", address, 32'h0000_0000);
    check("rst_writedata", writedata, 32'h0000_0000);
    check("rst_ctl", {23'h0, read, write, byteenable, instr_valid, data_valid, bus_error}, 32'h0);
    check("rst_instr_rdata", instr_rdata, 32'h0000_0000);
    check("rst_data_rdata", data_rdata, 32'h0000_0000);
    reset = 1'b0;
    @(negedge clk);

    // 1: fetch with one stall cycle
    wr_mode = 2'd1; snap_a = stall_cnt; snap_b = instr_pulses;
    instr_req = 1'b1; instr_addr = 32'hBFC0_0000;
    wait_sig("t1_wait", 0, 20);
    check("t1_rdata", instr_rdata, 32'h2402_0005);
    check("t1_be", {28'h0, byteenable}, 32'h0000_000F);
    check("t1_addr", address, 32'hBFC0_0000);
    instr_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_pulses", 32'(instr_pulses - snap_b), 32'd1);
    check("t1_stalls", 32'(stall_cnt - snap_a), 32'd1);
    check("t1_valid_low", {31'h0, instr_valid}, 32'h0);

    // 2: halfword store then load of the same word
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'hBFC0_0010;
    data_wdata = 32'hDEAD_BEEF; data_byteenable = 4'b0011;
    wait_sig("t2_store_wait", 1, 20);
    check("t2_mem", mem[4], 32'h0000_BEEF);
    check("t2_wdata", writedata, 32'hDEAD_BEEF);
    data_req = 1'b0;
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b0; data_wdata = 32'h0;
    wait_sig("t2_load_wait", 1, 20);
    check("t2_load_rdata", data_rdata, 32'h0000_BEEF);
    check("t2_load_be", {28'h0, byteenable}, 32'h0000_0003);
    data_req = 1'b0;
    repeat (2) @(negedge clk);

    // 3: simultaneous requests, data goes first
    snap_b = instr_pulses;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'hBFC0_0010; data_byteenable = 4'b1111;
    instr_req = 1'b1; instr_addr = 32'hBFC0_0000;
    wait_sig("t3_strobe", 2, 10);
    check("t3_first_addr", address, 32'hBFC0_0010);
    wait_sig("t3_data_wait", 1, 20);
    check("t3_data_rdata", data_rdata, 32'h0000_BEEF);
    check("t3_no_fetch_yet", 32'(instr_pulses - snap_b), 32'd0);
    data_req = 1'b0;
    wait_sig("t3_fetch_wait", 0, 20);
    check("t3_fetch_rdata", instr_rdata, 32'h2402_0005);
    instr_req = 1'b0;
    repeat (2) @(negedge clk);

    // 4: permanent stall, abort after 8 cycles
    wr_mode = 2'd2; snap_a = stall_cnt;
    instr_req = 1'b1; instr_addr = 32'hBFC0_0000;
    wait_sig("t4_wait", 0, 30);
    check("t4_bus_error", {31'h0, bus_error}, 32'h1);
    check("t4_rdata", instr_rdata, 32'hFFFF_FFFF);
    check("t4_read_low", {31'h0, read}, 32'h0);
    instr_req = 1'b0;
    @(negedge clk);
    check("t4_stalls", 32'(stall_cnt - snap_a), 32'd8);
    check("t4_err_pulse", {30'h0, bus_error, instr_valid}, 32'h0);
    @(negedge clk);

    // 5: reset during a stalled read
    instr_req = 1'b1;
    wait_sig("t5_strobe", 2, 10);
    reset = 1'b1; instr_req = 1'b0;
    snap_a = instr_pulses;
    @(negedge clk);
    check("t5_read_low", {31'h0, read}, 32'h0);
    check("t5_state_idle", {30'h0, dut.state_r}, 32'h0);
    check("t5_address", address, 32'h0000_0000);
    reset = 1'b0; wr_mode = 2'd1;
    repeat (3) @(negedge clk);
    check("t5_no_pulse", 32'(instr_pulses - snap_a), 32'd0);
    instr_req = 1'b1; instr_addr = 32'hBFC0_0000;
    wait_sig("t5_fresh_wait", 0, 20);
    check("t5_fresh_rdata", instr_rdata, 32'h2402_0005);
    check("t5_fresh_err", {31'h0, bus_error}, 32'h0);
    instr_req = 1'b0;
    repeat (2) @(negedge clk);

    // 6: word load at a misaligned address
    wr_mode = 2'd0; snap_a = strobe_cycles;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'hBFC0_0002; data_byteenable = 4'b1111;
`ifdef MIPS_BUS_MISALIGN_CHECK_EN
    wait_sig("t6_wait", 1, 10);
    check("t6_misaligned", {31'h0, misaligned}, 32'h1);
    check("t6_rdata", data_rdata, 32'h0000_0000);
    check("t6_no_strobe", 32'(strobe_cycles - snap_a), 32'd0);
`else
    wait_sig("t6_strobe", 2, 10);
    check("t6_masked_addr", address, 32'hBFC0_0000);
    wait_sig("t6_wait", 1, 20);
    check("t6_rdata", data_rdata, 32'h2402_0005);
`endif
    data_req = 1'b0;
    repeat (2) @(negedge clk);

    // Whole-run bus protocol properties
    check("never_read_and_write", 32'(rw_both_cnt), 32'd0);
    check("hold_during_stall", 32'(hold_viol_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_master.md
Name: mips_cpu_bus_master

Overview:
- Avalon-MM master bridging the CPU core's two request ports (instruction fetch, data load/store) onto the single 32-bit memory bus.
- Arbitrates between the two ports and drives address/read/write/byteenable/writedata.
- Holds bus signals stable while waitrequest is high, captures the registered readdata, and returns a one-cycle valid strobe to the requesting port.
- Sits directly upstream of the 32x65536 wait-state RAM in the test harness.

Parameters:
- READ_LATENCY, 1, cycles from accepting edge (read=1, waitrequest=0) until readdata is valid; legal range 1..4.
- WAIT_TIMEOUT, 64, maximum consecutive waitrequest-high cycles before the transaction is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_req  in  1  fetch request; level held until instr_valid.
- instr_addr  in  32  fetch byte address.
- instr_valid  out  1  one-cycle pulse; instr_rdata valid.
- instr_rdata  out  32  fetched word.
- data_req  in  1  data request; level held until data_valid.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data, already lane-aligned.
- data_byteenable  in  4  byte lanes for the access.
- data_valid  out  1  one-cycle pulse; load data valid, or store committed.
- data_rdata  out  32  load word, raw lanes.
- bus_error  out  1  one-cycle pulse on timeout abort, concurrent with the *_valid of the aborted port.
- address  out  32  Avalon address; bits [1:0] forced to 0.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- waitrequest  in  1  slave stall.
- writedata  out  32  Avalon write data.
- byteenable  out  4  Avalon byte enables; 4'b1111 for fetches.
- readdata  in  32  Avalon read data.

Behaviour:
- Reset values: read=0, write=0, address=0, writedata=0, byteenable=0, instr_valid=0, data_valid=0, bus_error=0, instr_rdata=0, data_rdata=0, state=IDLE, counters=0.
- Reset asserted mid-transaction drops read/write on the next edge; no valid pulse is issued.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If data_req, select the data port; else if instr_req, select the fetch port.
  - Data has fixed priority over fetch.
  - On selection, register address/byteenable/writedata/direction, go to REQ. The bus is driven from the following cycle.
- REQ:
  - Drive read or write.
  - An edge with waitrequest=0 accepts the transaction:
    - Write: go to DONE.
    - Read: go to RESP with lat_cnt=READ_LATENCY.
  - waitrequest=1: hold all bus outputs unchanged and increment wait_cnt.
  - If WAIT_TIMEOUT!=0 and wait_cnt reaches WAIT_TIMEOUT: deassert the strobe, pulse bus_error, return *_rdata=32'hFFFFFFFF, go to DONE.
- RESP:
  - read/write low.
  - Decrement lat_cnt; at 1, capture readdata into the port's rdata register and go to DONE.
- DONE:
  - Pulse the selected port's *_valid for exactly one cycle, go to IDLE.
  - Minimum throughput: one transaction per 3 cycles plus waits plus latency.
- read and write are never high together.
- Outputs are held stable throughout waitrequest.
- A request that is dropped before *_valid is a protocol violation by the CPU. The master completes the transaction regardless.
- Address 0 is passed through unchanged; the halt address is the CPU's responsibility.

Optional Feature:
- Macro: MIPS_BUS_MISALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned (1 bit, reset 0).
  - In IDLE, a selected request with addr[1:0]!=0 and byteenable==4'b1111, or addr[0]!=0 with a two-lane byteenable, is not issued.
  - Goes straight to DONE; pulses misaligned with *_valid; rdata=0.
- Undefined: port is absent; address bits [1:0] are masked silently.

Decomposition:
- Package mips_bus_pkg:
  - typedef enum logic[1:0] bus_state_t {IDLE, REQ, RESP, DONE}.
  - typedef enum logic bus_port_t {PORT_INSTR, PORT_DATA}.
  - localparam BE_WORD=4'b1111 and ERR_WORD=32'hFFFFFFFF.
- Sub-module: mips_bus_wait_counter, a saturating counter with clear/enable/limit-hit. It is reused for the wait_cnt and lat_cnt instances.

Test Plan:
- Fetch only, RAM with alternating waitrequest, word 0xBFC00000=0x24020005 -> read held through the wait cycle; instr_valid pulses once with instr_rdata=0x24020005; byteenable=4'b1111.
- Store data_addr=0xBFC00010, wdata=0xDEADBEEF, be=4'b0011, then load of the same address -> data_valid for both; load returns 0x0000BEEF with be=4'b0011.
- data_req and instr_req asserted in the same cycle -> data transaction is issued first; fetch is issued after data_valid; no cycle has read&write=1.
- waitrequest tied to 1, WAIT_TIMEOUT=8 -> after 8 stall cycles read drops; bus_error and instr_valid pulse together; instr_rdata=0xFFFFFFFF.
- reset asserted during REQ with waitrequest=1 -> next edge read=0, state IDLE, no valid pulse; a fresh fetch afterwards completes normally.
- With MIPS_BUS_MISALIGN_CHECK_EN, load addr=0xBFC00002, be=4'b1111 -> no bus read; misaligned=1 and data_valid=1 in the same cycle; data_rdata=0.
